// File: rtl/fx2_slave_fifo_model.sv
// Device-side model of the FX2 slave FIFO: two OUT endpoints (EP2/EP4) drained by the FPGA and
// two IN endpoints (EP6/EP8) filled by the FPGA, with a host stream port on the far side of each.
module fx2_slave_fifo_model #(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                        usb_ifclk,
  input  logic                        reset,
  input  logic                        usb_slwr,
  input  logic                        usb_slrd,
  input  logic                        usb_sloe,
  input  logic [1:0]                  usb_addr,
  input  logic [7:0]                  usb_data_in,
  output logic [7:0]                  usb_data_out,
  output logic                        usb_ep2_empty,
  output logic                        usb_ep4_empty,
  output logic                        usb_ep6_full,
  output logic                        usb_ep8_full,
  input  logic                        host_wr_valid,
  input  logic                        host_wr_ep,
  input  logic [7:0]                  host_wr_data,
  output logic                        host_wr_ready,
  input  logic                        host_rd_ep,
  input  logic                        host_rd_ready,
  output logic                        host_rd_valid,
  output logic [7:0]                  host_rd_data,
  output logic [4*(ADDR_WIDTH+1)-1:0] ep_count,
  output logic [3:0]                  proto_err
);

  localparam int unsigned CW  = ADDR_WIDTH + 1;
  localparam int unsigned NEP = 4;

  logic [7:0]            mem    [NEP][DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr [NEP];
  logic [ADDR_WIDTH-1:0] rd_ptr [NEP];
  logic [CW-1:0]         count  [NEP];
  logic [7:0]            head   [NEP];
  logic [7:0]            wdata  [NEP];
  logic [NEP-1:0]        empty;
  logic [NEP-1:0]        full;
  logic [NEP-1:0]        push;
  logic [NEP-1:0]        pop;
  logic [3:0]            err_set;
  logic                  rd_only;
  logic                  wr_only;

  // Per-endpoint status; an empty FIFO presents 0 rather than a stale memory word.
  always_comb begin
    empty    = '0;
    full     = '0;
    ep_count = '0;
    for (int i = 0; i < NEP; i++) begin
      empty[i] = (count[i] == CW'(0));
      full[i]  = (count[i] == CW'(DEPTH));
      head[i]  = empty[i] ? 8'h00 : mem[i][rd_ptr[i]];
      ep_count[i*CW +: CW] = count[i];
    end
  end

  assign wdata[0] = host_wr_data;
  assign wdata[1] = host_wr_data;
  assign wdata[2] = usb_data_in;
  assign wdata[3] = usb_data_in;

  assign usb_ep2_empty = empty[0];
  assign usb_ep4_empty = empty[1];
  assign usb_ep6_full  = full[2];
  assign usb_ep8_full  = full[3];

  assign usb_data_out  = (usb_sloe && !usb_addr[1]) ? (usb_addr[0] ? head[1] : head[0]) : 8'h00;
  assign host_wr_ready = host_wr_ep ? !full[1] : !full[0];
  assign host_rd_valid = host_rd_ep ? !empty[3] : !empty[2];
  assign host_rd_data  = host_rd_ep ? head[3] : head[2];

  // Strobes asserted together cancel each other, so each direction acts only when alone.
  assign rd_only = usb_slrd && !usb_slwr;
  assign wr_only = usb_slwr && !usb_slrd;

  assign push[0] = host_wr_valid && !host_wr_ep && !full[0];
  assign push[1] = host_wr_valid &&  host_wr_ep && !full[1];
  assign push[2] = wr_only && (usb_addr == 2'd2) && !full[2];
  assign push[3] = wr_only && (usb_addr == 2'd3) && !full[3];

  assign pop[0]  = rd_only && (usb_addr == 2'd0) && !empty[0];
  assign pop[1]  = rd_only && (usb_addr == 2'd1) && !empty[1];
  assign pop[2]  = host_rd_ready && !host_rd_ep && !empty[2];
  assign pop[3]  = host_rd_ready &&  host_rd_ep && !empty[3];

  assign err_set[0] = rd_only && !usb_addr[1] && (usb_addr[0] ? empty[1] : empty[0]);
  assign err_set[1] = wr_only &&  usb_addr[1] && (usb_addr[0] ? full[3] : full[2]);
  assign err_set[2] = (rd_only && usb_addr[1]) || (wr_only && !usb_addr[1]);
  assign err_set[3] = usb_slrd && usb_slwr;

  // Pointers, counts and sticky errors.
  always_ff @(posedge usb_ifclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NEP; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      proto_err <= '0;
    end else begin
      for (int i = 0; i < NEP; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + ADDR_WIDTH'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + ADDR_WIDTH'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
      proto_err <= proto_err | err_set;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge usb_ifclk) begin
    for (int i = 0; i < NEP; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= wdata[i];
    end
  end

endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// Directed bench for fx2_slave_fifo_model: stimulus queues expected bytes per endpoint and a
// negedge monitor checks every byte the DUT hands to the FPGA or the host.
module tb_fx2_slave_fifo_model;

  localparam int unsigned CW = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        usb_slwr, usb_slrd, usb_sloe;
  logic [1:0]  usb_addr;
  logic [7:0]  usb_data_in, usb_data_out;
  logic        usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full;
  logic        host_wr_valid, host_wr_ep, host_wr_ready;
  logic [7:0]  host_wr_data;
  logic        host_rd_ep, host_rd_ready, host_rd_valid;
  logic [7:0]  host_rd_data;
  logic [39:0] ep_count;
  logic [3:0]  proto_err;

  logic [7:0]  exp_q [4][$];
  int          tests = 0;
  int          fails = 0;
  int          hidx;
  int          fidx;

  fx2_slave_fifo_model #(.DEPTH(512), .ADDR_WIDTH(9)) dut (
    .usb_ifclk    (clk),
    .reset        (rst_n),
    .usb_slwr     (usb_slwr),
    .usb_slrd     (usb_slrd),
    .usb_sloe     (usb_sloe),
    .usb_addr     (usb_addr),
    .usb_data_in  (usb_data_in),
    .usb_data_out (usb_data_out),
    .usb_ep2_empty(usb_ep2_empty),
    .usb_ep4_empty(usb_ep4_empty),
    .usb_ep6_full (usb_ep6_full),
    .usb_ep8_full (usb_ep8_full),
    .host_wr_valid(host_wr_valid),
    .host_wr_ep   (host_wr_ep),
    .host_wr_data (host_wr_data),
    .host_wr_ready(host_wr_ready),
    .host_rd_ep   (host_rd_ep),
    .host_rd_ready(host_rd_ready),
    .host_rd_valid(host_rd_valid),
    .host_rd_data (host_rd_data),
    .ep_count     (ep_count),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] cnt(input int e);
    return ep_count[e*CW +: CW];
  endfunction

  // Monitor: every transfer the upcoming edge will perform is checked against the model queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (usb_slrd && !usb_slwr && usb_sloe && !usb_addr[1]) begin
        fidx = usb_addr[0] ? 1 : 0;
        if (exp_q[fidx].size() > 0) check("fpga_rd_data", 40'(usb_data_out), 40'(exp_q[fidx].pop_front()));
      end
      if (host_rd_ready) begin
        hidx = host_rd_ep ? 3 : 2;
        if (exp_q[hidx].size() > 0) begin
          check("host_rd_valid", 40'(host_rd_valid), 40'd1);
          check("host_rd_data", 40'(host_rd_data), 40'(exp_q[hidx].pop_front()));
        end else begin
          check("host_rd_valid_empty", 40'(host_rd_valid), 40'd0);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_push(input int ep, input logic [7:0] d);
    host_wr_valid = 1'b1;
    host_wr_ep    = ep[0];
    host_wr_data  = d;
    exp_q[ep].push_back(d);
    tick();
    host_wr_valid = 1'b0;
  endtask

  task automatic fpga_push(input int ep, input logic [7:0] d, input bit accepted);
    usb_addr    = ep[1:0];
    usb_data_in = d;
    usb_slwr    = 1'b1;
    if (accepted) exp_q[ep].push_back(d);
    tick();
    usb_slwr = 1'b0;
  endtask

  task automatic fpga_pop(input int ep);
    usb_addr = ep[1:0];
    usb_sloe = 1'b1;
    usb_slrd = 1'b1;
    tick();
    usb_slrd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    usb_slwr = 1'b0; usb_slrd = 1'b0; usb_sloe = 1'b1; usb_addr = 2'd0; usb_data_in = 8'h00;
    host_wr_valid = 1'b0; host_wr_ep = 1'b0; host_wr_data = 8'h00;
    host_rd_ep = 1'b0; host_rd_ready = 1'b0;

    // Reset state
    #12;
    check("rst_ep2_empty", 40'(usb_ep2_empty), 40'd1);
    check("rst_ep4_empty", 40'(usb_ep4_empty), 40'd1);
    check("rst_ep6_full", 40'(usb_ep6_full), 40'd0);
    check("rst_ep8_full", 40'(usb_ep8_full), 40'd0);
    check("rst_data_out", 40'(usb_data_out), 40'd0);
    check("rst_host_rd_valid", 40'(host_rd_valid), 40'd0);
    check("rst_host_wr_ready", 40'(host_wr_ready), 40'd1);
    check("rst_proto_err", 40'(proto_err), 40'd0);
    check("rst_ep_count", ep_count, 40'd0);
    rst_n = 1'b1;
    tick();

    // EP2 host -> FPGA, first-word-fall-through
    host_push(0, 8'h11);
    check("ep2_empty_after_push", 40'(usb_ep2_empty), 40'd0);
    check("ep2_fwft_head", 40'(usb_data_out), 40'h11);
    host_push(0, 8'h22);
    host_push(0, 8'h33);
    check("ep2_count3", 40'(cnt(0)), 40'd3);
    fpga_pop(0);
    fpga_pop(0);
    check("ep2_not_empty_before_last", 40'(usb_ep2_empty), 40'd0);
    fpga_pop(0);
    check("ep2_empty_after_3pops", 40'(usb_ep2_empty), 40'd1);
    check("proto_err_clean", 40'(proto_err), 40'd0);

    // EP6 fill to DEPTH, overflow, host drain
    for (int i = 0; i < 512; i++) fpga_push(2, 8'(i), 1'b1);
    check("ep6_full", 40'(usb_ep6_full), 40'd1);
    check("ep6_count512", 40'(cnt(2)), 40'd512);
    check("host_wr_ready_ep2_still", 40'(host_wr_ready), 40'd1);
    fpga_push(2, 8'hEE, 1'b0);
    check("ep6_overflow_err", 40'(proto_err), 40'b0010);
    check("ep6_count_after_ovf", 40'(cnt(2)), 40'd512);
    host_rd_ep = 1'b0;
    host_rd_ready = 1'b1;
    repeat (512) tick();
    host_rd_ready = 1'b0;
    check("ep6_drained", 40'(host_rd_valid), 40'd0);
    check("ep6_not_full", 40'(usb_ep6_full), 40'd0);

    // EP4 wrap-around with concurrent push/pop, fill held at 5
    for (int i = 0; i < 5; i++) host_push(1, 8'(i * 3));
    for (int i = 5; i < 700; i++) begin
      host_wr_valid = 1'b1; host_wr_ep = 1'b1; host_wr_data = 8'(i * 3);
      exp_q[1].push_back(8'(i * 3));
      usb_addr = 2'd1; usb_sloe = 1'b1; usb_slrd = 1'b1;
      tick();
      host_wr_valid = 1'b0; usb_slrd = 1'b0;
    end
    check("ep4_count_steady", 40'(cnt(1)), 40'd5);
    repeat (5) fpga_pop(1);
    check("ep4_empty_after_wrap", 40'(usb_ep4_empty), 40'd1);
    check("ep4_no_error", 40'(proto_err), 40'b0010);

    // EP8 simultaneous FPGA push and host pop
    for (int i = 0; i < 5; i++) fpga_push(3, 8'hA0 + 8'(i), 1'b1);
    check("ep8_count5", 40'(cnt(3)), 40'd5);
    for (int i = 0; i < 3; i++) begin
      usb_addr = 2'd3; usb_data_in = 8'hC0 + 8'(i); usb_slwr = 1'b1;
      exp_q[3].push_back(8'hC0 + 8'(i));
      host_rd_ep = 1'b1; host_rd_ready = 1'b1;
      tick();
      usb_slwr = 1'b0; host_rd_ready = 1'b0;
      check("ep8_count_unchanged", 40'(cnt(3)), 40'd5);
    end
    host_rd_ep = 1'b1;
    host_rd_ready = 1'b1;
    repeat (5) tick();
    host_rd_ready = 1'b0;
    check("ep8_drained", 40'(host_rd_valid), 40'd0);
    fpga_pop(0);
    check("ep2_underflow_err", 40'(proto_err), 40'b0011);
    check("ep2_count_after_underflow", 40'(cnt(0)), 40'd0);

    // Wrong-direction and conflicting strobes
    fpga_pop(2);
    check("wrong_dir_err", 40'(proto_err), 40'b0111);
    host_push(0, 8'hA1);
    host_push(0, 8'hA2);
    usb_addr = 2'd0; usb_slwr = 1'b1; usb_slrd = 1'b1;
    tick();
    usb_slwr = 1'b0; usb_slrd = 1'b0;
    check("both_strobes_err", 40'(proto_err), 40'b1111);
    check("both_strobes_counts", ep_count, 40'd2);

    // Async reset between edges with EP2 half full
    for (int i = 0; i < 254; i++) host_push(0, 8'(i));
    check("ep2_half_full", 40'(cnt(0)), 40'd256);
    usb_addr = 2'd0; usb_sloe = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ep2_empty", 40'(usb_ep2_empty), 40'd1);
    check("async_ep_count", ep_count, 40'd0);
    check("async_proto_err", 40'(proto_err), 40'd0);
    check("async_data_out", 40'(usb_data_out), 40'd0);
    check("async_wr_ready", 40'(host_wr_ready), 40'd1);
    exp_q[0].delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    host_push(0, 8'h5A);
    fpga_pop(0);
    check("post_reset_ep2_empty", 40'(usb_ep2_empty), 40'd1);

    check("queues_drained", 40'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 40'd0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
